// File: rtl/sha2_hash_state_bank.sv
// SHA-2 hash state bank: init/accumulate of H[0..NUM_WORDS-1] plus a valid/ready serial digest readout.
// Define HASH_STATE_BUILTIN_IV_EN to make init load the FIPS 180-4 IV instead of iv_i.
module sha2_hash_state_bank #(
  parameter int WORD_W    = 32,
  parameter int NUM_WORDS = 8
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          init,
  input  logic [NUM_WORDS*WORD_W-1:0]   iv_i,
  input  logic                          acc,
  input  logic [NUM_WORDS*WORD_W-1:0]   work_i,
  input  logic                          rd_start,
  output logic [WORD_W-1:0]             dout,
  output logic                          dout_valid,
  input  logic                          dout_ready,
  output logic                          dout_last,
  output logic                          busy,
  output logic [NUM_WORDS*WORD_W-1:0]   h_o
);

  localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                      state_q, state_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic [WORD_W-1:0]           h_q [NUM_WORDS];
  logic                        do_init, do_acc;
  logic [NUM_WORDS*WORD_W-1:0] iv_sel;

`ifdef HASH_STATE_BUILTIN_IV_EN
  // Word 0 sits in the least significant position, matching the iv_i packing.
  localparam logic [255:0] SHA256_IV = {
    32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
    32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667};
  localparam logic [511:0] SHA512_IV = {
    64'h5be0cd19137e2179, 64'h1f83d9abfb41bd6b, 64'h9b05688c2b3e6c1f, 64'h510e527fade682d1,
    64'ha54ff53a5f1d36f1, 64'h3c6ef372fe94f82b, 64'hbb67ae8584caa73b, 64'h6a09e667f3bcc908};

  generate
    if (WORD_W == 64) begin : g_iv512
      assign iv_sel = SHA512_IV[NUM_WORDS*WORD_W-1:0];
    end else begin : g_iv256
      assign iv_sel = SHA256_IV[NUM_WORDS*WORD_W-1:0];
    end
  endgenerate
`else
  assign iv_sel = iv_i;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    do_init    = 1'b0;
    do_acc     = 1'b0;
    dout_valid = 1'b0;
    dout_last  = 1'b0;
    busy       = 1'b0;
    case (state_q)
      IDLE: begin
        // Strict priority; losing requests are dropped, not remembered.
        if (init) begin
          do_init = 1'b1;
        end else if (acc) begin
          do_acc = 1'b1;
        end else if (rd_start) begin
          state_d = STREAM;
          idx_d   = '0;
        end
      end
      STREAM: begin
        dout_valid = 1'b1;
        busy       = 1'b1;
        dout_last  = (idx_q == LAST_IDX);
        if (dout_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NUM_WORDS; i++) h_q[i] <= '0;
    end else if (do_init) begin
      for (int i = 0; i < NUM_WORDS; i++) h_q[i] <= iv_sel[i*WORD_W +: WORD_W];
    end else if (do_acc) begin
      // Per-word modular add: carries never leave a word.
      for (int i = 0; i < NUM_WORDS; i++) h_q[i] <= h_q[i] + work_i[i*WORD_W +: WORD_W];
    end
  end

  assign dout = busy ? h_q[idx_q] : '0;

  generate
    for (genvar g = 0; g < NUM_WORDS; g++) begin : g_hview
      assign h_o[g*WORD_W +: WORD_W] = h_q[g];
    end
  endgenerate

endmodule

// File: tb/tb_sha2_hash_state_bank.sv
// Randomized self-checking bench for sha2_hash_state_bank (default build: init loads iv_i).
module tb_sha2_hash_state_bank;

  localparam int W = 32;
  localparam int N = 8;

  logic           CLK = 1'b0;
  logic           RST = 1'b1;
  logic           init = 1'b0;
  logic [N*W-1:0] iv_i = '0;
  logic           acc = 1'b0;
  logic [N*W-1:0] work_i = '0;
  logic           rd_start = 1'b0;
  logic [W-1:0]   dout;
  logic           dout_valid;
  logic           dout_ready = 1'b0;
  logic           dout_last;
  logic           busy;
  logic [N*W-1:0] h_o;

  int checks = 0;
  int errors = 0;

  // Reference model: the hash words as plain numbers.
  logic [W-1:0] exp_h [N];

  sha2_hash_state_bank #(.WORD_W(W), .NUM_WORDS(N)) dut (
    .CLK(CLK), .RST(RST), .init(init), .iv_i(iv_i), .acc(acc), .work_i(work_i),
    .rd_start(rd_start), .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .dout_last(dout_last), .busy(busy), .h_o(h_o)
  );

  always #5 CLK = ~CLK;

  function automatic logic [N*W-1:0] exp_packed();
    logic [N*W-1:0] v;
    for (int i = 0; i < N; i++) v[i*W +: W] = exp_h[i];
    return v;
  endfunction

  function automatic logic [N*W-1:0] rand_vec();
    logic [N*W-1:0] v;
    for (int i = 0; i < N; i++) v[i*W +: W] = $urandom;
    return v;
  endfunction

  // Drives one IDLE-cycle request, advances one edge and updates the model.
  task automatic idle_cycle(input bit i_init, input bit i_acc, input bit i_rd,
                            input logic [N*W-1:0] iv, input logic [N*W-1:0] wk);
    init = i_init; acc = i_acc; rd_start = i_rd; iv_i = iv; work_i = wk;
    @(posedge CLK); #1;
    init = 1'b0; acc = 1'b0; rd_start = 1'b0;
    if (i_init) begin
      for (int k = 0; k < N; k++) exp_h[k] = iv[k*W +: W];
    end else if (i_acc) begin
      for (int k = 0; k < N; k++) exp_h[k] = W'((64'(exp_h[k]) + 64'(wk[k*W +: W])) % (64'd1 << W));
    end
  endtask

  // mode 0: always ready; 1: ready pattern 1,0,0,1; 2: random ready plus ignored requests.
  task automatic readout(input int mode);
    int k = 0;
    int cyc = 0;
    bit rdy;
    logic [N*W-1:0] h_before;
    h_before = exp_packed();
    rd_start = 1'b1;
    @(posedge CLK); #1;
    rd_start = 1'b0;
    while (k < N && cyc < 200) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: rdy = 1'(($urandom & 32'h1));
      endcase
      dout_ready = rdy;
      if (mode == 2) begin
        init = 1'($urandom); acc = 1'($urandom); rd_start = 1'($urandom);
        iv_i = rand_vec(); work_i = rand_vec();
      end
      checks++;
      if (dout_valid !== 1'b1 || busy !== 1'b1) begin
        errors++;
        $display("FAIL stream_valid beat %0d: valid=%b busy=%b, required 1/1", k, dout_valid, busy);
      end
      checks++;
      if (dout !== exp_h[k]) begin
        errors++;
        $display("FAIL stream_dout beat %0d: got %h, required %h", k, dout, exp_h[k]);
      end
      checks++;
      if (dout_last !== (k == N - 1)) begin
        errors++;
        $display("FAIL stream_last beat %0d: got %b, required %b", k, dout_last, (k == N - 1));
      end
      @(posedge CLK); #1;
      if (rdy) k++;
      cyc++;
    end
    dout_ready = 1'b0; init = 1'b0; acc = 1'b0; rd_start = 1'b0;
    checks++;
    if (k != N) begin
      errors++;
      $display("FAIL stream_timeout: beats %0d, required %0d", k, N);
    end
    checks++;
    if (busy !== 1'b0 || dout_valid !== 1'b0 || dout_last !== 1'b0 || dout !== '0) begin
      errors++;
      $display("FAIL stream_end: busy=%b valid=%b last=%b dout=%h, required 0/0/0/0",
               busy, dout_valid, dout_last, dout);
    end
    checks++;
    if (h_o !== h_before) begin
      errors++;
      $display("FAIL stream_hold: h_o=%h, required %h", h_o, h_before);
    end
  endtask

  task automatic test_reset();
    logic [N*W-1:0] iv;
    #3;
    checks++;
    if (h_o !== '0 || busy !== 1'b0 || dout_valid !== 1'b0 || dout !== '0 || dout_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: h_o=%h busy=%b valid=%b dout=%h last=%b, required all 0",
               h_o, busy, dout_valid, dout, dout_last);
    end
    #4 RST = 1'b0;
    for (int k = 0; k < N; k++) exp_h[k] = '0;
    iv = rand_vec();
    idle_cycle(1'b1, 1'b0, 1'b0, iv, '0);
    checks++;
    if (h_o !== exp_packed()) begin
      errors++;
      $display("FAIL reset_first_edge_init: h_o=%h, required %h", h_o, exp_packed());
    end
  endtask

  task automatic test_acc_wrap();
    logic [N*W-1:0] iv, wk;
    iv = rand_vec(); wk = rand_vec();
    iv[W-1:0] = 32'hFFFF_FFFF;
    wk[W-1:0] = 32'h0000_0002;
    idle_cycle(1'b1, 1'b0, 1'b0, iv, '0);
    idle_cycle(1'b0, 1'b1, 1'b0, '0, wk);
    checks++;
    if (h_o[W-1:0] !== 32'h0000_0001) begin
      errors++;
      $display("FAIL acc_wrap_word0: got %h, required 00000001", h_o[W-1:0]);
    end
    checks++;
    if (h_o !== exp_packed()) begin
      errors++;
      $display("FAIL acc_all_words: h_o=%h, required %h", h_o, exp_packed());
    end
  endtask

  task automatic test_priority();
    logic [N*W-1:0] iv, wk;
    iv = rand_vec(); wk = rand_vec();
    idle_cycle(1'b1, 1'b1, 1'b1, iv, wk);
    checks++;
    if (h_o !== iv || busy !== 1'b0) begin
      errors++;
      $display("FAIL prio_init_over_acc: h_o=%h busy=%b, required %h busy=0", h_o, busy, iv);
    end
    wk = rand_vec();
    idle_cycle(1'b0, 1'b1, 1'b1, '0, wk);
    checks++;
    if (h_o !== exp_packed() || busy !== 1'b0) begin
      errors++;
      $display("FAIL prio_acc_over_rd: h_o=%h busy=%b, required %h busy=0", h_o, busy, exp_packed());
    end
  endtask

  task automatic test_reset_mid_stream();
    logic [N*W-1:0] iv;
    rd_start = 1'b1;
    @(posedge CLK); #1;
    rd_start = 1'b0;
    dout_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (dout !== exp_h[k]) begin
        errors++;
        $display("FAIL rst_pre_beat %0d: got %h, required %h", k, dout, exp_h[k]);
      end
      @(posedge CLK); #1;
    end
    dout_ready = 1'b0;
    checks++;
    if (dout !== exp_h[3] || dout_valid !== 1'b1) begin
      errors++;
      $display("FAIL rst_at_index3: dout=%h valid=%b, required %h valid=1", dout, dout_valid, exp_h[3]);
    end
    #2 RST = 1'b1;
    #1;
    for (int k = 0; k < N; k++) exp_h[k] = '0;
    checks++;
    if (dout_valid !== 1'b0 || busy !== 1'b0 || h_o !== '0 || dout !== '0) begin
      errors++;
      $display("FAIL rst_async: valid=%b busy=%b h_o=%h dout=%h, required all 0", dout_valid, busy, h_o, dout);
    end
    #1 RST = 1'b0;
    iv = rand_vec();
    idle_cycle(1'b1, 1'b0, 1'b0, iv, '0);
    checks++;
    if (h_o !== exp_packed() || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_recover: h_o=%h busy=%b, required %h busy=0", h_o, busy, exp_packed());
    end
  endtask

  task automatic test_random_ops();
    int op;
    for (int n = 0; n < 40; n++) begin
      op = $urandom_range(0, 5);
      if (op == 5) begin
        readout(2);
      end else begin
        idle_cycle(op == 0 || op == 3, op == 1 || op == 3, 1'b0, rand_vec(), rand_vec());
        checks++;
        if (h_o !== exp_packed() || busy !== 1'b0) begin
          errors++;
          $display("FAIL random_op %0d iter %0d: h_o=%h busy=%b, required %h busy=0",
                   op, n, h_o, busy, exp_packed());
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_acc_wrap();
    readout(0);
    readout(1);
    readout(0);
    test_priority();
    readout(2);
    test_reset_mid_stream();
    readout(1);
    test_random_ops();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sha2_hash_state_bank.md
SHA2_HASH_STATE_BANK -- requirements
Module: sha2_hash_state_bank

Interface
REQ-001 Parameter WORD_W, default 32, meaning hash word width in bits; only 32 (SHA-256) and 64 (SHA-512) are legal.
REQ-002 Parameter NUM_WORDS, default 8, meaning number of hash state words H[0..NUM_WORDS-1].
REQ-003 CLK  input  1  clock; all state updates on rising edge.
REQ-004 RST  input  1  reset, asynchronous, active-high.
REQ-005 init  input  1  load initial hash value into all words.
REQ-006 iv_i  input  NUM_WORDS*WORD_W  external initial value; word i at bits [i*WORD_W +: WORD_W].
REQ-007 acc  input  1  accumulate working variables into the state (end of compression).
REQ-008 work_i  input  NUM_WORDS*WORD_W  working variables a..h, same packing as iv_i.
REQ-009 rd_start  input  1  request serial readout of the digest.
REQ-010 dout  output  WORD_W  current readout word.
REQ-011 dout_valid  output  1  dout holds a valid word.
REQ-012 dout_ready  input  1  consumer accepts dout this cycle.
REQ-013 dout_last  output  1  current readout word is H[NUM_WORDS-1].
REQ-014 busy  output  1  high while in STREAM.
REQ-015 h_o  output  NUM_WORDS*WORD_W  parallel view of all state words, same packing.

Function
REQ-016 The FSM SHALL have two states: IDLE and STREAM.
REQ-017 In IDLE with init=1, every H[i] SHALL take its initial value on the next edge.
REQ-018 In IDLE with acc=1 and init=0, every H[i] SHALL become (H[i] + work_i word i) mod 2^WORD_W on the next edge; carries are discarded and do not cross words.
REQ-019 Priority in IDLE: init > acc > rd_start; lower-priority requests in the same cycle SHALL be ignored, not queued.
REQ-020 In IDLE with rd_start=1 and init=acc=0, the FSM SHALL enter STREAM on the next edge with index=0; dout_valid SHALL be 1 from that cycle.
REQ-021 In STREAM, dout SHALL equal H[index]; dout_last SHALL be 1 iff index=NUM_WORDS-1.
REQ-022 A beat SHALL transfer when dout_valid && dout_ready; index then increments, or the FSM returns to IDLE on the last beat.
REQ-023 With dout_ready=0, dout, dout_last and index SHALL hold; there is no timeout.
REQ-024 In STREAM, init, acc and rd_start SHALL be ignored and H SHALL hold.
REQ-025 Outside STREAM, dout_valid=0, dout_last=0, busy=0 and dout=0.
REQ-026 h_o SHALL always reflect the registered H with no combinational path from inputs.
REQ-027 Back-to-back digests SHALL be supported: rd_start may be asserted in the cycle after the last beat.

Reset
REQ-028 With RST=1, all H[i] and index SHALL be 0 and FSM=IDLE, asynchronously, independent of CLK.
REQ-029 A reset during STREAM SHALL drop dout_valid immediately; no partial digest resumes.
REQ-030 After RST falls, the block SHALL accept requests on the first rising edge.

Configuration
REQ-031 Macro HASH_STATE_BUILTIN_IV_EN defined: init loads the FIPS 180-4 constant IV (SHA-256 for WORD_W=32, SHA-512 for WORD_W=64, with NUM_WORDS=8); iv_i is ignored.
REQ-032 Macro HASH_STATE_BUILTIN_IV_EN undefined: init loads iv_i; no constants are synthesised.

Verification
REQ-033 Macro defined, WORD_W=32: init pulse -> H[0]=0x6a09e667, H[7]=0x5be0cd19.
REQ-034 H[0]=0xFFFFFFFF, work word 0=0x00000002, acc pulse -> H[0]=0x00000001; other words add independently.
REQ-035 rd_start with dout_ready=1 -> 8 consecutive beats H[0]..H[7], dout_last only on beat 8, busy low the cycle after.
REQ-036 Readout with dout_ready toggled 1,0,0,1 -> no word skipped or repeated; dout is stable while stalled.
REQ-037 init and acc asserted together in IDLE -> IV is loaded and acc has no effect; acc pulsed during STREAM -> H unchanged.
REQ-038 RST pulsed mid-STREAM at index 3 -> dout_valid=0 immediately, h_o all 0, FSM=IDLE.
